alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_regfile.sv | 49 ++++
 rtl/alu_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, FSM states and
// datapath widths, plus small opcode-classification helpers.
package alu_pkg;

    localparam int DATA_W  = 9;
    localparam int INSTR_W = 13;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_ADD  = 4'b0011,
        OP_SHL  = 4'b0100,
        OP_SHR  = 4'b0101,
        OP_MOV  = 4'b0110,
        OP_SUB  = 4'b0111,
        OP_ADDI = 4'b1000,
        OP_SUBI = 4'b1001,
        OP_MOVI = 4'b1010,
        OP_NOP  = 4'b1011,
        OP_ILL0 = 4'b1100,
        OP_ILL1 = 4'b1101,
        OP_ILL2 = 4'b1110,
        OP_HALT = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    function automatic logic writes_rf(input opcode_e op);
        return op <= OP_MOVI;
    endfunction

    function automatic logic uses_imm(input opcode_e op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MOVI);
    endfunction

    function automatic logic is_illegal(input opcode_e op);
        return (op == OP_ILL0) || (op == OP_ILL1) || (op == OP_ILL2);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: NREGS x DATA_W, two operand read ports, a debug
// read port and one synchronous write port. Out-of-range indices read as zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [1:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] rf [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we && int'(waddr) == i) begin
                    rf[i] <= wdata;
                end
            end
        end
    end

    // Mux by comparison so any NREGS works with the fixed 2-bit instruction fields.
    always_comb begin
        ra_data  = '0;
        rb_data  = '0;
        dbg_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (int'(ra_addr) == i)  ra_data  = rf[i];
            if (int'(rb_addr) == i)  rb_data  = rf[i];
            if (int'(dbg_addr) == i) dbg_data = rf[i];
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Non-pipelined instruction sequencer: fetches, decodes, drives an external ALU
// and writes back, one instruction every four cycles plus fetch wait.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int NREGS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_out,
    output logic               halted,
    output logic               illegal,
    input  logic [1:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_e             state, state_nxt;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  res;
    logic [DATA_W-1:0]  rf_a, rf_b;
    logic               fetch_req;
    logic               rf_we;
    opcode_e            ir_op;
    logic [1:0]         ir_rd, ir_rs;
    logic [4:0]         ir_imm;

    assign ir_op  = opcode_e'(ir[12:9]);
    assign ir_rd  = ir[8:7];
    assign ir_rs  = ir[6:5];
    assign ir_imm = ir[4:0];

    // Gate with rst_n so the request drops the moment reset asserts, even
    // though the reset state itself is FETCH.
    assign imem_req  = fetch_req & rst_n;
    assign imem_addr = pc;

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (ir_rd),
        .ra_data  (rf_a),
        .rb_addr  (ir_rs),
        .rb_data  (rf_b),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (ir_rd),
        .wdata    (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fetch_req = 1'b0;
        rf_we     = 1'b0;
        case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (imem_ack) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = (ir_op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB: begin
                rf_we     = writes_rf(ir_op);
                state_nxt = S_FETCH;
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // alu_op is only non-NOP during EXEC: loaded leaving DECODE, cleared leaving EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            ir      <= '0;
            res     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= OP_NOP;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                        pc <= pc + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    if (ir_op == OP_HALT) begin
                        halted <= 1'b1;
                    end else begin
                        alu_a  <= rf_a;
                        alu_b  <= uses_imm(ir_op) ? {4'b0000, ir_imm} : rf_b;
                        alu_op <= is_illegal(ir_op) ? OP_NOP : ir_op;
                        if (is_illegal(ir_op)) illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    res    <= alu_out;
                    alu_op <= OP_NOP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU plus an
// instruction-level reference model, driven by directed and random programs.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [12:0] imem_data = '0;
    logic [3:0]  alu_op;
    logic [8:0]  alu_a, alu_b, alu_out;
    logic        halted, illegal;
    logic [1:0]  dbg_sel = '0;
    logic [8:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [8:0] m_rf [4];
    logic [7:0] m_pc;
    bit         saw_halt_op = 0;
    logic [3:0] op_log [$];

    alu_sequencer #(.PC_W(8), .NREGS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .halted    (halted),
        .illegal   (illegal),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_op == 4'hF) saw_halt_op = 1;
            if (alu_op != 4'hB) op_log.push_back(alu_op);
        end
    end

    // The external ALU and the model's arithmetic share these instruction semantics.
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a << b[3:0];
            4'd5:    return a >> b[3:0];
            4'd6:    return b;
            4'd7:    return a - b;
            4'd8:    return a + b;
            4'd9:    return a - b;
            4'd10:   return b;
            default: return a;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_op, alu_a, alu_b);

    task automatic model_reset();
        for (int r = 0; r < 4; r++) m_rf[r] = '0;
        m_pc = '0;
    endtask

    task automatic model_exec(input logic [12:0] ins);
        logic [3:0] op;
        logic [8:0] a, b;
        op = ins[12:9];
        m_pc = m_pc + 8'd1;
        if (op <= 4'd10) begin
            a = m_rf[ins[8:7]];
            b = (op >= 4'd8) ? {4'b0000, ins[4:0]} : m_rf[ins[6:5]];
            m_rf[ins[8:7]] = alu_fn(op, a, b);
        end
    endtask

    // Serves one fetch; expects to be entered at a falling edge.
    task automatic do_instr(input logic [12:0] ins, input int wt, input bit noise,
                            output int lat, output bit stable);
        int         start;
        logic [7:0] a0;
        bit         got;
        stable = 1;
        lat    = -1;
        got    = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (imem_req === 1'b1) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL fetch_timeout: imem_req=%b required 1", imem_req);
            return;
        end
        a0    = imem_addr;
        start = cyc;
        imem_ack = 1'b0;
        repeat (wt) begin
            imem_data = 13'($urandom);
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== a0) stable = 0;
        end
        imem_ack  = 1'b1;
        imem_data = ins;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 13'($urandom);
        model_exec(ins);
        if (ins[12:9] == 4'hF) return;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (imem_req === 1'b1) begin
                got = 1;
                imem_ack = 1'b0;
            end else begin
                imem_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_data = 13'($urandom);
                @(negedge clk);
            end
        end
        imem_ack = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL next_fetch_timeout: imem_req=%b required 1", imem_req);
        end else begin
            lat = cyc - start;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 8'd0) begin errors++; $display("[TB] FAIL rst_addr: got %0d want 0", imem_addr); end
        checks++; if (alu_op !== 4'hB) begin errors++; $display("[TB] FAIL rst_alu_op: got %h want b", alu_op); end
        checks++; if (alu_a !== 9'd0 || alu_b !== 9'd0) begin errors++; $display("[TB] FAIL rst_operands: got a=%0d b=%0d want 0", alu_a, alu_b); end
        checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags: got halted=%b illegal=%b want 0", halted, illegal); end
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            checks++; if (dbg_data !== 9'd0) begin errors++; $display("[TB] FAIL rst_rf%0d: got %0d want 0", r, dbg_data); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin errors++; $display("[TB] FAIL first_fetch: got req=%b addr=%0d want 1/0", imem_req, imem_addr); end
        @(negedge clk);
    endtask

    task automatic test_movi();
        int lat; bit st;
        do_instr(13'b1010_01_00_00101, 0, 0, lat, st);
        dbg_sel = 2'd1; #1;
        checks++; if (dbg_data !== 9'd5) begin errors++; $display("[TB] FAIL movi_r1: got %0d want 5", dbg_data); end
        checks++; if (imem_addr !== 8'd1) begin errors++; $display("[TB] FAIL movi_pc: got %0d want 1", imem_addr); end
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        int lat; bit st;
        do_instr(13'b1010_10_00_00011, 0, 0, lat, st);
        op_log.delete();
        do_instr(13'b0011_01_10_00000, 0, 0, lat, st);
        dbg_sel = 2'd1; #1;
        checks++; if (dbg_data !== 9'd8) begin errors++; $display("[TB] FAIL add_r1: got %0d want 8", dbg_data); end
        checks++; if (op_log.size() != 1 || op_log[0] !== 4'b0011) begin errors++; $display("[TB] FAIL add_alu_op: got %0d entries first=%h want 1 entry 3", op_log.size(), (op_log.size() > 0) ? op_log[0] : 4'hx); end
        @(negedge clk);
        do_instr(13'b1010_01_00_00101, 0, 0, lat, st);
        op_log.delete();
        do_instr(13'b0111_01_10_00000, 0, 0, lat, st);
        dbg_sel = 2'd1; #1;
        checks++; if (dbg_data !== 9'd2) begin errors++; $display("[TB] FAIL sub_r1: got %0d want 2", dbg_data); end
        checks++; if (op_log.size() != 1 || op_log[0] !== 4'b0111) begin errors++; $display("[TB] FAIL sub_alu_op: got %0d entries first=%h want 1 entry 7", op_log.size(), (op_log.size() > 0) ? op_log[0] : 4'hx); end
        @(negedge clk);
    endtask

    task automatic test_wait();
        int lat; bit st;
        do_instr(13'b1011_00_00_00000, 0, 0, lat, st);
        checks++; if (lat != 4) begin errors++; $display("[TB] FAIL latency_nowait: got %0d want 4", lat); end
        do_instr(13'b1010_11_00_00111, 3, 0, lat, st);
        checks++; if (lat != 7) begin errors++; $display("[TB] FAIL latency_wait3: got %0d want 7", lat); end
        checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL wait_stable: got %b want 1", st); end
        dbg_sel = 2'd3; #1;
        checks++; if (dbg_data !== 9'd7) begin errors++; $display("[TB] FAIL wait_r3: got %0d want 7", dbg_data); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat; bit st; int wt;
        logic [12:0] ins;
        for (int n = 0; n < 40; n++) begin
            ins = 13'($urandom);
            ins[12:9] = 4'($urandom_range(0, 11));
            wt = $urandom_range(0, 2);
            do_instr(ins, wt, 1, lat, st);
            checks++; if (lat != wt + 4) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", n, lat, wt + 4); end
            checks++; if (imem_addr !== m_pc) begin errors++; $display("[TB] FAIL rand_pc[%0d]: got %0d want %0d", n, imem_addr, m_pc); end
            for (int r = 0; r < 4; r++) begin
                dbg_sel = 2'(r); #1;
                checks++; if (dbg_data !== m_rf[r]) begin errors++; $display("[TB] FAIL rand_rf%0d[%0d] ins=%b: got %0d want %0d", r, n, ins, dbg_data, m_rf[r]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_nop();
        int lat; bit st;
        do_instr(13'b1011_01_10_10101, 0, 0, lat, st);
        checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL nop_illegal: got %b want 0", illegal); end
        do_instr(13'b1101_10_01_11111, 0, 0, lat, st);
        checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL ill_flag: got %b want 1", illegal); end
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            checks++; if (dbg_data !== m_rf[r]) begin errors++; $display("[TB] FAIL ill_rf%0d: got %0d want %0d", r, dbg_data, m_rf[r]); end
        end
        @(negedge clk);
        do_instr(13'b1011_00_00_00000, 0, 0, lat, st);
        checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL ill_sticky: got %b want 1", illegal); end
    endtask

    task automatic test_pc_wrap();
        int lat; bit st;
        for (int g = 0; g < 300 && m_pc != 8'hFF; g++) do_instr(13'b1011_00_00_00000, 0, 0, lat, st);
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_at255: got %0d want 255", imem_addr); end
        do_instr(13'b1011_00_00_00000, 0, 0, lat, st);
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL wrap_to0: got %0d want 0", imem_addr); end
    endtask

    task automatic test_reset_exec();
        int lat; bit st; bit got;
        do_instr(13'b1010_00_00_01001, 0, 0, lat, st);
        imem_ack  = 1'b1;
        imem_data = 13'b0011_00_00_00000;
        @(negedge clk);
        imem_ack = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (alu_op === 4'b0011) got = 1;
            else @(negedge clk);
        end
        checks++; if (!got) begin errors++; $display("[TB] FAIL exec_reach: alu_op=%h want 3", alu_op); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_req: got %b want 0", imem_req); end
        model_reset();
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            checks++; if (dbg_data !== 9'd0) begin errors++; $display("[TB] FAIL rst_mid_rf%0d: got %0d want 0", r, dbg_data); end
        end
        checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_illegal: got %b want 0", illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin errors++; $display("[TB] FAIL rst_mid_refetch: got req=%b addr=%0d want 1/0", imem_req, imem_addr); end
        @(negedge clk);
    endtask

    task automatic test_halt();
        int lat; bit st; bit req_seen;
        do_instr(13'b1010_10_00_10001, 0, 0, lat, st);
        do_instr(13'b1111_00_00_00000, 0, 0, lat, st);
        req_seen = 0;
        repeat (12) begin
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = 13'b1010_10_00_00001;
            @(negedge clk);
            if (imem_req !== 1'b0) req_seen = 1;
        end
        imem_ack = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag: got %b want 1", halted); end
        checks++; if (req_seen) begin errors++; $display("[TB] FAIL halt_req: got 1 want 0"); end
        checks++; if (saw_halt_op) begin errors++; $display("[TB] FAIL halt_alu_op: got f want never f"); end
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            checks++; if (dbg_data !== m_rf[r]) begin errors++; $display("[TB] FAIL halt_rf%0d: got %0d want %0d", r, dbg_data, m_rf[r]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_movi();
        test_add_sub();
        test_wait();
        test_random();
        test_illegal_nop();
        test_pc_wrap();
        test_reset_exec();
        test_random();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
